// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// parameter defaults and the requester index width helper.
package mul_share_arbiter_pkg;

   // Sequencer states; encodings are fixed so they can be read in waveforms.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_GRANT = 3'b001,
      ST_WAIT  = 3'b010,
      ST_RESP  = 3'b011,
      ST_CLEAR = 3'b100
   } arb_state_e;

   localparam int N_REQ_DEFAULT   = 2;
   localparam int WIDTH_DEFAULT   = 64;
   localparam int TIMEOUT_DEFAULT = 255;
   localparam int WD_BITS         = 8;   // watchdog counter width

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Round-robin priority encoder: returns the first asserted request at or
// after the pointer, wrapping past the highest index.
module rr_pick
   import mul_share_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             found
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] offset;
   logic [IDX_W:0]   sum;

   // Rotate so the pointer slot lands at bit 0, then take the lowest set bit.
   always_comb begin
      rot    = N_REQ'({req, req} >> ptr);
      offset = '0;
      found  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found  = 1'b1;
            offset = IDX_W'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= (IDX_W + 1)'(N_REQ)) begin
         sum = sum - (IDX_W + 1)'(N_REQ);
      end
      winner = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier core among N_REQ requesters. Grants round-robin,
// drives the start/clear handshake, returns the product with a one-cycle
// strobe and aborts operations that never signal done.
module mul_share_arbiter
   import mul_share_arbiter_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEFAULT,
   parameter int WIDTH       = WIDTH_DEFAULT,
   parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_multiplier,
   input  logic [N_REQ*WIDTH-1:0] req_multiplicand,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic                   rsp_error,
   output logic [2*WIDTH-1:0]     rsp_result,
   output logic                   busy,
   output logic [WIDTH-1:0]       m_multiplier,
   output logic [WIDTH-1:0]       m_multiplicand,
   output logic                   m_opstart,
   output logic                   m_opclear,
   input  logic                   m_opdone,
   input  logic [2*WIDTH-1:0]     m_result
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam logic [WD_BITS-1:0] WD_LAST  = WD_BITS'(TIMEOUT_CYC - 1);
   localparam logic [WD_BITS-1:0] WD_MAX   = '1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0]   ONE_HOT0 = N_REQ'(1);

   arb_state_e           state_reg, state_next;
   logic [IDX_W-1:0]     ptr_reg;
   logic [IDX_W-1:0]     win_reg;
   logic [WIDTH-1:0]     a_reg, b_reg;
   logic [2*WIDTH-1:0]   result_reg;
   logic                 error_reg;
   logic [WD_BITS-1:0]   wd_reg;
   logic [N_REQ-1:0]     gnt_reg, rsp_valid_reg;
   logic                 m_opstart_reg, m_opclear_reg, busy_reg;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_found;
   logic                 timeout_hit;

   logic [WIDTH-1:0]     a_slot [N_REQ];
   logic [WIDTH-1:0]     b_slot [N_REQ];

   // Unpack the per-requester operand buses into indexable slots.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign a_slot[gi] = req_multiplier[gi*WIDTH +: WIDTH];
      assign b_slot[gi] = req_multiplicand[gi*WIDTH +: WIDTH];
   end

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .winner (pick_idx),
      .found  (pick_found)
   );

   assign timeout_hit = (wd_reg >= WD_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; requests only matter while idle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (pick_found) state_next = ST_GRANT;
         ST_GRANT: state_next = m_opdone ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (m_opdone || timeout_hit) state_next = ST_RESP;
         ST_RESP:  state_next = ST_CLEAR;
         ST_CLEAR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Operand, result, watchdog and pointer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg    <= '0;
         win_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         error_reg  <= 1'b0;
         wd_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_found) begin
                  win_reg <= pick_idx;
                  a_reg   <= a_slot[pick_idx];
                  b_reg   <= b_slot[pick_idx];
               end
            end
            ST_GRANT: begin
               wd_reg <= '0;
               if (m_opdone) begin
                  result_reg <= m_result;
                  error_reg  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (m_opdone) begin
                  result_reg <= m_result;
                  error_reg  <= 1'b0;
               end else begin
                  // Saturating count: a stuck core must never wrap the watchdog.
                  if (wd_reg != WD_MAX) wd_reg <= wd_reg + 1'b1;
                  if (timeout_hit) begin
                     result_reg <= '0;
                     error_reg  <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               ptr_reg <= (win_reg == LAST_IDX) ? '0 : win_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Registered handshake outputs, decoded from the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_reg       <= '0;
         rsp_valid_reg <= '0;
         m_opstart_reg <= 1'b0;
         m_opclear_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         gnt_reg       <= (state_reg == ST_IDLE && pick_found) ? (ONE_HOT0 << pick_idx) : '0;
         rsp_valid_reg <= (state_next == ST_RESP) ? (ONE_HOT0 << win_reg) : '0;
         m_opstart_reg <= (state_next == ST_GRANT) || (state_next == ST_WAIT);
         m_opclear_reg <= (state_next == ST_IDLE) || (state_next == ST_CLEAR);
         busy_reg      <= (state_next != ST_IDLE);
      end
   end

   assign gnt            = gnt_reg;
   assign rsp_valid      = rsp_valid_reg;
   assign rsp_error      = error_reg;
   assign rsp_result     = result_reg;
   assign busy           = busy_reg;
   assign m_multiplier   = a_reg;
   assign m_multiplicand = b_reg;
   assign m_opstart      = m_opstart_reg;
   assign m_opclear      = m_opclear_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural multiplier model
// that raises done a fixed number of start cycles after the operation begins.
module tb_mul_share_arbiter;

   localparam int N   = 2;
   localparam int W   = 64;
   localparam int TO  = 255;
   localparam int LAT = 3;

   logic             clk;
   logic             reset_n;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_multiplier, req_multiplicand;
   logic [N-1:0]     gnt, rsp_valid;
   logic             rsp_error;
   logic [2*W-1:0]   rsp_result;
   logic             busy;
   logic [W-1:0]     m_multiplier, m_multiplicand;
   logic             m_opstart, m_opclear, m_opdone;
   logic [2*W-1:0]   m_result;

   int vectors;
   int miscompares;
   bit stall;
   int mcnt;

   mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req              (req),
      .req_multiplier   (req_multiplier),
      .req_multiplicand (req_multiplicand),
      .gnt              (gnt),
      .rsp_valid        (rsp_valid),
      .rsp_error        (rsp_error),
      .rsp_result       (rsp_result),
      .busy             (busy),
      .m_multiplier     (m_multiplier),
      .m_multiplicand   (m_multiplicand),
      .m_opstart        (m_opstart),
      .m_opclear        (m_opclear),
      .m_opdone         (m_opdone),
      .m_result         (m_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: done after LAT sampled start cycles, cleared by m_opclear.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt     <= 0;
         m_opdone <= 1'b0;
         m_result <= '0;
      end else if (m_opclear) begin
         mcnt     <= 0;
         m_opdone <= 1'b0;
         m_result <= '0;
      end else if (m_opstart && !m_opdone && !stall) begin
         mcnt <= mcnt + 1;
         if (mcnt == LAT - 1) begin
            m_opdone <= 1'b1;
            m_result <= {64'b0, m_multiplier} * {64'b0, m_multiplicand};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_gnt(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (gnt == '0 && cyc < 50);
      check("gnt_seen", 128'(gnt != '0), 128'(1));
   endtask

   task automatic wait_rsp(input int bound, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (rsp_valid == '0 && cyc < bound);
      check("rsp_seen", 128'(rsp_valid != '0), 128'(1));
      $display("rsp: valid=%b err=%b result=%h after %0d cycles", rsp_valid, rsp_error, rsp_result, cyc);
   endtask

   task automatic set_ops(input int slot, input logic [W-1:0] a, input logic [W-1:0] b);
      req_multiplier[slot*W +: W]   = a;
      req_multiplicand[slot*W +: W] = b;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int cyc;
      int gap;
      int clr_busy;
      logic [N-1:0] exp_mask;
      vectors          = 0;
      miscompares      = 0;
      stall            = 1'b0;
      req              = '0;
      req_multiplier   = '0;
      req_multiplicand = '0;
      reset_n          = 1'b0;

      // Reset state.
      tick();
      tick();
      check("rst_ctrl", 128'({gnt, rsp_valid, rsp_error, busy, m_opstart, m_opclear}), 128'(0));
      check("rst_result", rsp_result, 128'(0));
      check("rst_operands", 128'({m_multiplier, m_multiplicand}), 128'(0));
      #2 reset_n = 1'b1;
      tick();
      check("post_rst_clear", 128'(m_opclear), 128'(1));

      // Simultaneous requests: pointer 0 serves requester 0 then 1.
      set_ops(0, 64'd3, 64'd4);
      set_ops(1, 64'd7, 64'd8);
      req = 2'b11;
      wait_gnt(cyc);
      check("both_gnt0", 128'(gnt), 128'(2'b01));
      req[0] = 1'b0;
      wait_rsp(50, cyc);
      check("both_rsp0_valid", 128'(rsp_valid), 128'(2'b01));
      check("both_rsp0_result", rsp_result, 128'(12));
      gap      = 0;
      clr_busy = 0;
      do begin
         tick();
         gap++;
         if (m_opclear && busy) clr_busy++;
      end while (!m_opstart && gap < 10);
      check("start_gap_cycles", 128'(gap), 128'(3));
      check("clear_cycles", 128'(clr_busy), 128'(1));
      check("both_gnt1", 128'(gnt), 128'(2'b10));
      req[1] = 1'b0;
      wait_rsp(50, cyc);
      check("both_rsp1_valid", 128'(rsp_valid), 128'(2'b10));
      check("both_rsp1_result", rsp_result, 128'(56));

      // Single request 5*6 with latency and handshake levels.
      set_ops(0, 64'd5, 64'd6);
      req = 2'b01;
      wait_gnt(cyc);
      check("t1_gnt", 128'(gnt), 128'(2'b01));
      check("t1_start_clear", 128'({m_opstart, m_opclear, busy}), 128'(3'b101));
      check("t1_operands", 128'({m_multiplier, m_multiplicand}), {64'd5, 64'd6});
      req = 2'b00;
      wait_rsp(50, cyc);
      check("t1_latency", 128'(cyc), 128'(4));
      check("t1_valid", 128'(rsp_valid), 128'(2'b01));
      check("t1_result", rsp_result, 128'(30));
      check("t1_error", 128'(rsp_error), 128'(0));
      tick();
      check("t1_clear_state", 128'({m_opclear, m_opstart, busy, rsp_valid}), 128'(5'b10100));
      tick();
      check("t1_idle_state", 128'({m_opclear, busy}), 128'(2'b10));

      // All-ones operands from requester 1.
      set_ops(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      req = 2'b10;
      wait_gnt(cyc);
      check("max_gnt", 128'(gnt), 128'(2'b10));
      req = 2'b00;
      wait_rsp(50, cyc);
      check("max_result", rsp_result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

      // Both requesters keep re-requesting: strict alternation 0,1,0,1...
      set_ops(0, 64'd1, 64'd3);
      set_ops(1, 64'd2, 64'd3);
      req = 2'b11;
      for (int k = 0; k < 20; k++) begin
         int idx;
         idx      = k % 2;
         exp_mask = N'(1) << idx;
         wait_gnt(cyc);
         check("alt_gnt", 128'(gnt), 128'(exp_mask));
         req[idx] = 1'b0;
         tick();
         set_ops(idx, W'(k + 3), 64'd3);
         req[idx] = 1'b1;
         wait_rsp(50, cyc);
         check("alt_result", {64'(rsp_valid), 64'(rsp_result)}, {64'(exp_mask), 64'((k + 1) * 3)});
         if (k == 19) req = 2'b00;
      end

      // Watchdog abort with done never arriving.
      stall = 1'b1;
      set_ops(0, 64'd9, 64'd9);
      req = 2'b01;
      wait_gnt(cyc);
      req = 2'b00;
      wait_rsp(400, cyc);
      check("to_latency", 128'(cyc), 128'(TO + 1));
      check("to_valid", 128'(rsp_valid), 128'(2'b01));
      check("to_error", 128'(rsp_error), 128'(1));
      check("to_result", rsp_result, 128'(0));
      stall = 1'b0;
      set_ops(0, 64'd11, 64'd12);
      req = 2'b01;
      wait_gnt(cyc);
      req = 2'b00;
      wait_rsp(50, cyc);
      check("after_to_result", {64'(rsp_error), 64'(rsp_result)}, {64'd0, 64'd132});

      // Reset in the middle of WAIT (pointer is 1 at this point).
      set_ops(1, 64'd2, 64'd2);
      req = 2'b10;
      wait_gnt(cyc);
      req = 2'b00;
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("midrst_ctrl", 128'({gnt, rsp_valid, rsp_error, busy, m_opstart, m_opclear}), 128'(0));
      check("midrst_data", 128'({m_multiplier, m_multiplicand}), 128'(0));
      tick();
      tick();
      check("midrst_no_rsp", 128'(rsp_valid), 128'(0));
      #2 reset_n = 1'b1;
      tick();
      check("midrst_release", 128'({m_opclear, busy, rsp_valid}), 128'(4'b1000));
      set_ops(0, 64'd6, 64'd7);
      set_ops(1, 64'd4, 64'd5);
      req = 2'b11;
      wait_gnt(cyc);
      check("midrst_ptr0", 128'(gnt), 128'(2'b01));
      req[0] = 1'b0;
      wait_rsp(50, cyc);
      check("midrst_r0", rsp_result, 128'(42));
      wait_gnt(cyc);
      check("midrst_gnt1", 128'(gnt), 128'(2'b10));
      req[1] = 1'b0;
      wait_rsp(50, cyc);
      check("midrst_r1", rsp_result, 128'(20));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 64x64 multiplier core (start/clear/done handshake, 128-bit result) among N_REQ requesters, such as factorial controllers and other bus-side compute masters. It latches the winner's operands and pulses start/clear in the order the multiplier needs. It returns the 128-bit product to that requester with a one-cycle valid, and guarantees one clear cycle between operations. A watchdog aborts operations that never complete.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 64, operand width; product is 2*WIDTH
TIMEOUT_CYC, 255, max cycles in WAIT before abort (8-bit counter)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; held until its gnt
req_multiplier  in  N_REQ*WIDTH  packed operand A, slot i at [i*WIDTH +: WIDTH]
req_multiplicand  in  N_REQ*WIDTH  packed operand B, same packing
gnt  out  N_REQ  one-hot, one-cycle grant/ack
rsp_valid  out  N_REQ  one-hot, one-cycle response strobe
rsp_error  out  1  valid with rsp_valid; 1 = timeout abort
rsp_result  out  2*WIDTH  product; valid only while rsp_valid != 0
busy  out  1  1 in every state except IDLE
m_multiplier  out  WIDTH  operand A to multiplier
m_multiplicand  out  WIDTH  operand B to multiplier
m_opstart  out  1  multiplier start level
m_opclear  out  1  multiplier clear level
m_opdone  in  1  multiplier done
m_result  in  2*WIDTH  multiplier product

Behaviour:
- All outputs registered or decoded from state registers. Async reset (reset_n=0) forces:
  - state=IDLE, rr pointer=0, all outputs 0, operand and result registers 0, watchdog=0.
- Reset mid-operation aborts silently: no rsp_valid; the in-flight requester must re-request.
- FSM states: IDLE, GRANT, WAIT, RESP, CLEAR.
- IDLE: m_opclear=1, m_opstart=0, busy=0.
  - If req!=0 at the clock edge, select winner w as the first set bit at or after the rr pointer, wrapping.
  - Latch w and that slot's operands; go to GRANT.
- GRANT (exactly 1 cycle): gnt[w]=1, m_opstart=1, m_opclear=0, operand outputs = latched values; watchdog cleared. Go to WAIT.
- WAIT: m_opstart held 1 with operands stable; watchdog increments each cycle.
  - m_opdone=1 sampled in GRANT or WAIT: latch m_result, rsp_error=0, go to RESP.
  - Watchdog reaches TIMEOUT_CYC with m_opdone=0: latch result=0, rsp_error=1, go to RESP.
- RESP (1 cycle): rsp_valid[w]=1, rsp_result=latched value, m_opstart=0.
  - Advance rr pointer to (w+1) mod N_REQ. Go to CLEAR.
- CLEAR (1 cycle): m_opclear=1, m_opstart=0. Go to IDLE.
- Latency: req seen at edge t -> gnt at t+1 -> rsp_valid one cycle after the edge where m_opdone is sampled.
  - Minimum back-to-back period is multiplier latency + 4 cycles.
- Requester rules:
  - Operands must be stable while req is high.
  - Requester drops req the cycle after gnt.
  - req still high in the first IDLE cycle after its own CLEAR is treated as a new request.
- Simultaneous requests are resolved only by the rr pointer. Lower index wins only when the pointer is at or below it.
- req changes outside IDLE are ignored until the next IDLE.
- m_opdone after an abort (in RESP/CLEAR) is ignored; the CLEAR cycle resets the multiplier.
- Product is passed through unmodified; the arbiter does no arithmetic except N_REQ wrap of the pointer and the 8-bit watchdog, which saturates and never wraps.

Decomposition:
- Shared package:
  - state encoding (3-bit, IDLE=000, GRANT=001, WAIT=010, RESP=011, CLEAR=100)
  - WIDTH default
  - TIMEOUT_CYC default
  - index width clog2(N_REQ)
- One sub-module: rr_pick (combinational round-robin priority encoder: req vector plus pointer -> winner index and found flag).
- State, pointer, and operand/result registers stay in the top module.

Test Plan:
- req[0]=1, A=5, B=6; model returns done after 3 cycles -> gnt[0] at t+1; rsp_valid[0] with rsp_result=30, rsp_error=0; m_opclear=1 in CLEAR.
- req=2'b11 together, A0=3,B0=4, A1=7,B1=8 -> requester 0 served first (result 12), then 1 (result 56); exactly one clear cycle between the two m_opstart pulses.
- Requester 0 re-requests immediately, requester 1 holding -> order 0,1,0,1 (strict alternation); no starvation over 20 operations.
- A=B=64'hFFFF_FFFF_FFFF_FFFF -> rsp_result = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- m_opdone tied 0 -> rsp_valid[w]=1, rsp_error=1, rsp_result=0 exactly TIMEOUT_CYC cycles into WAIT; next request is served normally.
- reset_n=0 mid-WAIT -> all outputs 0 immediately (async); no rsp_valid; after release, m_opclear=1 from the first edge and arbitration restarts at pointer 0.
